// File: rtl/io_mux_ctrl_pkg.sv
// Shared helpers for the io_mux ownership controller.
// Provides index-width and wrap-around arithmetic used by the controller and its arbiter.
package io_mux_ctrl_pkg;

   function automatic int idxWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int wrapNext(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/io_mux_ctrl_if.sv
// Request/grant bundle between the pad requesters and the io_mux ownership controller.
interface io_mux_ctrl_if #(
   parameter int REQCOUNT = 3,
   parameter int MUXWIDTH = 2
);
   logic [REQCOUNT-1:0]          req;
   logic [REQCOUNT*MUXWIDTH-1:0] req_func;
   logic [REQCOUNT-1:0]          grant;
   logic [MUXWIDTH-1:0]          func_select;
   logic                         busy;
   logic                         bad_req;

   modport master (
      output req, req_func,
      input  grant, func_select, busy, bad_req
   );

   modport slave (
      input  req, req_func,
      output grant, func_select, busy, bad_req
   );
endinterface

// File: rtl/io_mux_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first eligible requester at or after startIdx, wrapping.
// Produces both a one-hot and a binary form of the winner.
module rr_arbiter
   import io_mux_ctrl_pkg::*;
#(
   parameter int N  = 3,
   parameter int IW = idxWidth(N)
) (
   input  logic [N-1:0]  eligible_i,
   input  logic [IW-1:0] startIdx_i,
   output logic [N-1:0]  grantOh_o,
   output logic [IW-1:0] grantIdx_o,
   output logic          valid_o
);

   // Walk the ring once starting at startIdx; the first hit wins.
   always_comb begin
      int j;
      grantOh_o  = '0;
      grantIdx_o = '0;
      valid_o    = 1'b0;
      j          = 0;
      for (int off = 0; off < N; off++) begin
         j = int'(startIdx_i) + off;
         if (j >= N) begin
            j = j - N;
         end
         if (!valid_o && eligible_i[j]) begin
            valid_o    = 1'b1;
            grantIdx_o = IW'(j);
            grantOh_o  = N'(1) << j;
         end
      end
   end

endmodule

// File: rtl/io_mux_ctrl.sv
// Pad ownership controller: arbitrates requesters onto one io_mux function with a parked
// turnaround gap between owners. Outputs derive only from registered state.
module io_mux_ctrl
   import io_mux_ctrl_pkg::*;
#(
   parameter int TXCOUNT  = 2,
   parameter int RXCOUNT  = 2,
   parameter int REQCOUNT = 3,
   parameter int GUARD    = 2
) (
   input logic          clk,
   input logic          rst,
   io_mux_ctrl_if.slave bus
);

   localparam int MUXWIDTH = $clog2(TXCOUNT + RXCOUNT);
   localparam int IW       = idxWidth(REQCOUNT);
   localparam int CW       = idxWidth(GUARD + 1);

   localparam logic [MUXWIDTH-1:0] PARK        = '0;
   localparam logic [MUXWIDTH:0]   FUNC_LIMIT  = (MUXWIDTH + 1)'(TXCOUNT + RXCOUNT);
   localparam logic [CW-1:0]       GUARD_LAST  = CW'((GUARD > 0) ? GUARD - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GUARD  = 2'd1,
      ST_ACTIVE = 2'd2
   } state_e;

   state_e                state_q,    state_d;
   logic [IW-1:0]         winner_q,   winner_d;
   logic [REQCOUNT-1:0]   winnerOh_q, winnerOh_d;
   logic [MUXWIDTH-1:0]   func_q,     func_d;
   logic [CW-1:0]         guardCnt_q, guardCnt_d;
   logic [IW-1:0]         ptr_q,      ptr_d;
   logic                  badReq_q;

   logic [REQCOUNT-1:0]   eligible;
   logic [REQCOUNT-1:0]   badVec;
   logic [REQCOUNT-1:0]   arbEligible;
   logic [REQCOUNT-1:0]   arbOh;
   logic [IW-1:0]         arbIdx;
   logic                  arbValid;
   logic [MUXWIDTH-1:0]   arbFunc;
   logic                  launch;

   // A request only competes while it names a function the mux actually has.
   always_comb begin
      eligible = '0;
      badVec   = '0;
      for (int i = 0; i < REQCOUNT; i++) begin
         if (bus.req[i]) begin
            if ({1'b0, bus.req_func[i*MUXWIDTH +: MUXWIDTH]} < FUNC_LIMIT) begin
               eligible[i] = 1'b1;
            end else begin
               badVec[i] = 1'b1;
            end
         end
      end
   end

   // The releasing owner must not win the hand-over it is causing.
   assign arbEligible = (state_q == ST_ACTIVE) ? (eligible & ~winnerOh_q) : eligible;

   rr_arbiter #(
      .N  (REQCOUNT),
      .IW (IW)
   ) u_arb (
      .eligible_i (arbEligible),
      .startIdx_i (ptr_q),
      .grantOh_o  (arbOh),
      .grantIdx_o (arbIdx),
      .valid_o    (arbValid)
   );

   assign arbFunc = bus.req_func[int'(arbIdx)*MUXWIDTH +: MUXWIDTH];

   always_comb begin
      state_d    = state_q;
      winner_d   = winner_q;
      winnerOh_d = winnerOh_q;
      func_d     = func_q;
      guardCnt_d = guardCnt_q;
      ptr_d      = ptr_q;
      launch     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            launch = arbValid;
         end
         ST_GUARD: begin
            if (!bus.req[winner_q]) begin
               launch = arbValid;
               if (!arbValid) begin
                  state_d    = ST_IDLE;
                  guardCnt_d = '0;
               end
            end else if (guardCnt_q == GUARD_LAST) begin
               state_d    = ST_ACTIVE;
               guardCnt_d = '0;
               ptr_d      = IW'(wrapNext(int'(winner_q), REQCOUNT));
            end else begin
               guardCnt_d = guardCnt_q + CW'(1);
            end
         end
         ST_ACTIVE: begin
            if (!bus.req[winner_q]) begin
               launch = arbValid;
               if (!arbValid) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A fresh winner always starts a full turnaround unless there is none to serve.
      if (launch) begin
         winner_d   = arbIdx;
         winnerOh_d = arbOh;
         func_d     = arbFunc;
         guardCnt_d = '0;
         if (GUARD == 0) begin
            state_d = ST_ACTIVE;
            ptr_d   = IW'(wrapNext(int'(arbIdx), REQCOUNT));
         end else begin
            state_d = ST_GUARD;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         winner_q   <= '0;
         winnerOh_q <= '0;
         func_q     <= PARK;
         guardCnt_q <= '0;
         ptr_q      <= '0;
         badReq_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         winner_q   <= winner_d;
         winnerOh_q <= winnerOh_d;
         func_q     <= func_d;
         guardCnt_q <= guardCnt_d;
         ptr_q      <= ptr_d;
         badReq_q   <= |badVec;
      end
   end

   // Decoding from state alone lets reset park the pad without a clock edge.
   assign bus.grant       = (state_q == ST_ACTIVE) ? winnerOh_q : '0;
   assign bus.func_select = (state_q == ST_ACTIVE) ? func_q : PARK;
   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.bad_req     = badReq_q;

endmodule
